// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C responder target.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } resp_state_e;

  localparam logic I2C_DRV_LOW = 1'b0;
  localparam logic I2C_RELEASE = 1'b1;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_resp_sync.sv
// Bus input synchronizer with rise/fall pulses on the synced level.
// Define I2C_RESP_FILTER_EN to add a 3-sample majority glitch filter.
module i2c_resp_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   synced;
  logic                   prev;

  // Idle I2C bus is high, so everything resets to 1 to avoid spurious edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '1;
    else      chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign synced = chain[SYNC_STAGES-1];

`ifdef I2C_RESP_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], synced};
      filt <= (hist[1] & hist[0]) | (hist[1] & synced) | (hist[0] & synced);
    end
  end

  assign level = filt;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b1;
    else      prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_resp_target.sv
// I2C responder with auto-incrementing register pointer; SDA drive is wired-AND on the bus.
// Optional input glitch filter via I2C_RESP_FILTER_EN (see i2c_resp_sync).
module i2c_resp_target
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDXW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            sda_o,
  output logic            busy_o,
  output logic            wr_stb_o,
  output logic [IDXW-1:0] wr_idx_o,
  output logic [7:0]      wr_data_o,
  output logic            rd_stb_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .din(scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .din(sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  resp_state_e     state, state_n;
  logic [3:0]      bitcnt, bitcnt_n;
  logic [7:0]      shreg, shreg_n;
  logic [IDXW-1:0] ptr, ptr_n, wr_idx_n;
  logic            first, first_n;
  logic            sda_n, busy_n, wr_stb_n, rd_stb_n, reg_we;
  logic [7:0]      wr_data_n, rd_byte, din;
  logic [7:0]      regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      ptr       <= '0;
      first     <= 1'b0;
      sda_o     <= I2C_RELEASE;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      rd_stb_o  <= 1'b0;
      wr_idx_o  <= '0;
      wr_data_o <= '0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      first     <= first_n;
      sda_o     <= sda_n;
      busy_o    <= busy_n;
      wr_stb_o  <= wr_stb_n;
      rd_stb_o  <= rd_stb_n;
      wr_idx_o  <= wr_idx_n;
      wr_data_o <= wr_data_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= shreg;
    end
  end

  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    first_n   = first;
    sda_n     = sda_o;
    busy_n    = busy_o;
    wr_stb_n  = 1'b0;
    rd_stb_n  = 1'b0;
    wr_idx_n  = wr_idx_o;
    wr_data_n = wr_data_o;
    reg_we    = 1'b0;
    rd_byte   = regs[ptr];
    din       = {shreg[6:0], sda_lvl};

    if (stop_ev) begin
      state_n = IDLE;
      sda_n   = I2C_RELEASE;
      busy_n  = 1'b0;
    end else if (start_ev) begin
      state_n  = ADDR;
      bitcnt_n = '0;
      sda_n    = I2C_RELEASE;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bitcnt < 4'd8) begin
            shreg_n  = din;
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd7 && din[7:1] != DEV_ADDR) begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && bitcnt == 4'd8) begin
            sda_n   = I2C_DRV_LOW;
            busy_n  = 1'b1;
            state_n = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_n = '0;
            if (!shreg[0]) begin
              sda_n   = I2C_RELEASE;
              first_n = 1'b1;
              state_n = WR_BYTE;
            end else begin
              shreg_n  = rd_byte;
              rd_stb_n = 1'b1;
              ptr_n    = ptr + IDXW'(1);
              sda_n    = rd_byte[7];
              state_n  = RD_BYTE;
            end
          end
        end
        WR_BYTE: begin
          // The byte is committed on the falling edge that starts its ACK, so a
          // STOP/START anywhere before that leaves the register file untouched.
          if (scl_rise && bitcnt < 4'd8) begin
            shreg_n  = din;
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            sda_n    = I2C_DRV_LOW;
            bitcnt_n = '0;
            state_n  = WR_ACK;
            if (first) begin
              ptr_n   = shreg[IDXW-1:0];
              first_n = 1'b0;
            end else begin
              reg_we    = 1'b1;
              wr_stb_n  = 1'b1;
              wr_idx_n  = ptr;
              wr_data_n = shreg;
              ptr_n     = ptr + IDXW'(1);
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_n   = I2C_RELEASE;
            state_n = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bitcnt == 4'd7) begin
              sda_n    = I2C_RELEASE;
              bitcnt_n = '0;
              state_n  = RD_ACK;
            end else begin
              sda_n    = shreg[6];
              shreg_n  = {shreg[6:0], 1'b0};
              bitcnt_n = bitcnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_lvl) begin
            state_n = WAIT_STOP;
            busy_n  = 1'b0;
          end else if (scl_fall) begin
            shreg_n  = rd_byte;
            rd_stb_n = 1'b1;
            ptr_n    = ptr + IDXW'(1);
            sda_n    = rd_byte[7];
            state_n  = RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_resp_target.sv
// Directed bench: bit-banged I2C master against i2c_resp_target with hand-computed expectations.
module tb_i2c_resp_target;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_o, busy_o, wr_stb_o, rd_stb_o;
  logic [2:0] wr_idx_o;
  logic [7:0] wr_data_o;
  logic       sda_bus;

  assign sda_bus = msda & sda_o;

  i2c_resp_target #(.DEV_ADDR(7'h50), .NREGS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o),
    .busy_o(busy_o), .wr_stb_o(wr_stb_o), .wr_idx_o(wr_idx_o),
    .wr_data_o(wr_data_o), .rd_stb_o(rd_stb_o)
  );

  always #5 clk = ~clk;

  logic [15:0] wr_log[$];
  int          rd_cnt = 0;

  always @(negedge clk) begin
    if (wr_stb_o) wr_log.push_back({5'b0, wr_idx_o, wr_data_o});
    if (rd_stb_o) rd_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    wait_clk(2);  msda = 1'b1;
    wait_clk(H);  scl = 1'b1;
    wait_clk(H);  msda = 1'b0;
    wait_clk(H);  scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);  msda = 1'b0;
    wait_clk(H);  scl = 1'b1;
    wait_clk(H);  msda = 1'b1;
    wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(2);     msda = b;
    wait_clk(H - 2); scl = 1'b1;
    wait_clk(H);     scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(2);     msda = 1'b1;
    wait_clk(H - 2); scl = 1'b1;
    wait_clk(H / 2); b = sda_bus;
    wait_clk(H / 2); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    // 1: reset state and read of reg0
    wait_clk(5);
    @(negedge clk);
    check("rst_sda", sda_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_wr_stb", wr_stb_o, 1'b0);
    check("rst_rd_stb", rd_stb_o, 1'b0);
    rst = 1'b1;
    wait_clk(5);
    i2c_start();
    send_byte(8'hA1, ack);  check("t1_addr_ack", ack, 1'b0);
    recv_byte(1'b1, rd);    check("t1_reg0", rd, 8'h00);
    i2c_stop();
    check("t1_rd_cnt", rd_cnt, 1);

    // 2: pointer 2, write 0x11, 0x22
    wr_log.delete();
    i2c_start();
    send_byte(8'hA0, ack);  check("t2_addr_ack", ack, 1'b0);
    check("t2_busy", busy_o, 1'b1);
    send_byte(8'h02, ack);  check("t2_ptr_ack", ack, 1'b0);
    send_byte(8'h11, ack);  check("t2_d0_ack", ack, 1'b0);
    send_byte(8'h22, ack);  check("t2_d1_ack", ack, 1'b0);
    i2c_stop();
    check("t2_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t2_wr0", wr_log[0], 16'h0211);
      check("t2_wr1", wr_log[1], 16'h0322);
    end
    check("t2_busy_stop", busy_o, 1'b0);
    check("t2_sda_stop", sda_o, 1'b1);

    // 3: set pointer, repeated START, read two bytes
    rd_cnt = 0;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'hA1, ack);  check("t3_addr_ack", ack, 1'b0);
    recv_byte(1'b0, rd);    check("t3_rd0", rd, 8'h11);
    recv_byte(1'b1, rd);    check("t3_rd1", rd, 8'h22);
    wait_clk(6);
    check("t3_busy_nack", busy_o, 1'b0);
    i2c_stop();
    check("t3_rd_cnt", rd_cnt, 2);

    // 4: wrong address
    wr_log.delete();
    rd_cnt = 0;
    i2c_start();
    send_byte(8'hB0, ack);  check("t4_nack", ack, 1'b1);
    check("t4_busy", busy_o, 1'b0);
    i2c_stop();
    check("t4_nwr", wr_log.size(), 0);
    check("t4_nrd", rd_cnt, 0);

    // 5: pointer wrap and pointer truncation
    wr_log.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h07, ack);
    send_byte(8'hAA, ack);
    send_byte(8'hBB, ack);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h0B, ack);
    send_byte(8'h5C, ack);
    i2c_stop();
    check("t5_nwr", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("t5_wr7", wr_log[0], 16'h07AA);
      check("t5_wr0", wr_log[1], 16'h00BB);
      check("t5_wr3", wr_log[2], 16'h035C);
    end
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h07, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b0, rd);    check("t5_rd7", rd, 8'hAA);
    recv_byte(1'b1, rd);    check("t5_rd0", rd, 8'hBB);
    i2c_stop();

    // 6a: STOP after 4 data bits aborts the byte
    wr_log.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    wait_clk(4);
    check("t6_nwr", wr_log.size(), 0);
    check("t6_busy", busy_o, 1'b0);
    check("t6_sda", sda_o, 1'b1);

    // 6b: async reset mid-read while the responder drives a 0 bit (reg2 = 0x11)
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    wait_clk(H / 2);
    check("t6_drv_low", sda_o, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("t6_rst_sda", sda_o, 1'b1);
    check("t6_rst_busy", busy_o, 1'b0);
    scl = 1'b1;
    msda = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
